// File: rtl/cv32e40p_rf_recovery_ctrl.sv
// Register-file rollback sequencer: holds the core in setback, then streams the
// checkpointed register file from the shadow store into the core RF two registers per cycle.
module cv32e40p_rf_recovery_ctrl #(
    parameter int NUM_REGS       = 32,
    parameter int SETBACK_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [7:0]  recovery_count_o,
    output logic        shadow_update_en_o,
    output logic        setback_o,
    output logic        recover_o,
    output logic        shadow_re_o,
    output logic [5:0]  shadow_raddr_a_o,
    output logic [5:0]  shadow_raddr_b_o,
    input  logic [31:0] shadow_rdata_a_i,
    input  logic [31:0] shadow_rdata_b_i,
    output logic        regfile_we_a_o,
    output logic [5:0]  regfile_waddr_a_o,
    output logic [31:0] regfile_wdata_a_o,
    output logic        regfile_we_b_o,
    output logic [5:0]  regfile_waddr_b_o,
    output logic [31:0] regfile_wdata_b_o
);

    localparam int SBW = (SETBACK_CYCLES > 1) ? $clog2(SETBACK_CYCLES) : 1;
    localparam logic [SBW-1:0] SB_LAST  = SBW'(SETBACK_CYCLES - 1);
    localparam logic [4:0]     IDX_LAST = 5'(NUM_REGS / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETBACK,
        RESTORE,
        DRAIN,
        DONE
    } state_t;

    state_t         r_state;
    logic [SBW-1:0] r_sb_cnt;
    logic [4:0]     r_idx;
    logic [5:0]     r_raddr;
    logic [5:0]     r_waddr;
    logic           r_re;
    logic           r_we;
    logic           r_busy;
    logic           r_done;
    logic           r_setback;
    logic           r_recover;
    logic [7:0]     r_cnt;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state   <= IDLE;
            r_sb_cnt  <= '0;
            r_idx     <= '0;
            r_raddr   <= '0;
            r_waddr   <= '0;
            r_re      <= 1'b0;
            r_we      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_setback <= 1'b0;
            r_recover <= 1'b0;
            r_cnt     <= '0;
        end else begin
            // Write stage trails the read stage by exactly one cycle
            r_we <= r_re;
            if (r_re) begin
                r_waddr <= r_raddr;
            end
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_state   <= SETBACK;
                        r_busy    <= 1'b1;
                        r_setback <= 1'b1;
                        r_recover <= 1'b1;
                        r_sb_cnt  <= SB_LAST;
                    end
                end
                SETBACK: begin
                    if (r_sb_cnt == '0) begin
                        r_state   <= RESTORE;
                        r_setback <= 1'b0;
                        r_re      <= 1'b1;
                        r_raddr   <= '0;
                        r_idx     <= '0;
                    end else begin
                        r_sb_cnt <= r_sb_cnt - SBW'(1);
                    end
                end
                RESTORE: begin
                    if (r_idx == IDX_LAST) begin
                        r_state <= DRAIN;
                        r_re    <= 1'b0;
                    end else begin
                        r_idx   <= r_idx + 5'd1;
                        r_raddr <= r_raddr + 6'd2;
                    end
                end
                DRAIN: begin
                    r_state   <= DONE;
                    r_recover <= 1'b0;
                    r_done    <= 1'b1;
                    if (r_cnt != 8'hFF) begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy_o             = r_busy;
    assign done_o             = r_done;
    assign recovery_count_o   = r_cnt;
    assign shadow_update_en_o = ~r_busy;
    assign setback_o          = r_setback;
    assign recover_o          = r_recover;
    assign shadow_re_o        = r_re;

    // Addresses and data are forced to zero whenever their enable is low
    assign shadow_raddr_a_o  = r_re ? r_raddr : 6'd0;
    assign shadow_raddr_b_o  = r_re ? {r_raddr[5:1], 1'b1} : 6'd0;
    assign regfile_we_a_o    = r_we;
    assign regfile_we_b_o    = r_we;
    assign regfile_waddr_a_o = r_we ? r_waddr : 6'd0;
    assign regfile_waddr_b_o = r_we ? {r_waddr[5:1], 1'b1} : 6'd0;
    assign regfile_wdata_a_o = r_we ? shadow_rdata_a_i : 32'd0;
    assign regfile_wdata_b_o = r_we ? shadow_rdata_b_i : 32'd0;

endmodule
